// File: rtl/image_filter_3x3.sv
// image_filter_3x3: streaming 3x3 neighbourhood filter over a raster-order
// gray image. Two line buffers feed the right-hand column of a 3x3 window
// and one filtered pixel leaves per window shift once the window is full.
// Output (r,c) is produced when the window is centred on (r,c). A FLUSH
// phase injects zeros to push out the last IMG_W+1 centres.
//
// Handshake: the producer drives pix_in/pix_in_valid; a pixel is consumed
// on a rising edge where pix_in_valid and pix_in_ready are both high.
// pix_in_ready depends only on the FSM state. There is no output
// backpressure: pix_out_valid is a one-cycle strobe per output pixel.
module image_filter_3x3 #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] sel,
    input  logic [7:0] val,
    input  logic [7:0] pix_in,
    input  logic       pix_in_valid,
    output logic       pix_in_ready,
    output logic [7:0] pix_out,
    output logic       pix_out_valid,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(NPIX);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int FW   = $clog2(IMG_W + 2);

    logic [PW-1:0] in_cnt;
    logic [FW-1:0] flush_cnt;
    logic [CW-1:0] col_ptr;
    logic [CW-1:0] out_c;
    logic [RW-1:0] out_r;
    logic [2:0]    mode;
    logic [7:0]    operand;

    // lb_mid delays the stream by one line, lb_top by two lines.
    logic [7:0] lb_mid [IMG_W];
    logic [7:0] lb_top [IMG_W];
    // Left and centre window columns; the right column is the live column
    // coming from the line buffers and the incoming pixel.
    logic [7:0] win [3][2];
    logic [7:0] nw  [3][3];

    logic       accept;
    logic       flush_shift;
    logic       shift;
    logic       emit;
    logic [7:0] new_pix;

    logic [7:0]        p, up, dn, lf, rt, lu, ru, ld, rd;
    logic [8:0]        bright;
    logic [11:0]       gauss;
    logic signed [11:0] sharp;
    logic signed [11:0] gx, gy;
    logic [11:0]       ax, ay, sob;
    logic              border;
    logic [7:0]        result;

    function automatic logic [11:0] z(input logic [7:0] x);
        return {4'b0000, x};
    endfunction

    assign pix_in_ready = (fsm_state == S_STREAM);
    assign busy         = (fsm_state != S_IDLE);
    assign accept       = pix_in_valid && (fsm_state == S_STREAM);
    // FLUSH keeps one extra non-shifting cycle so busy stays high while the
    // final output is on the bus and drops together with frame_done.
    assign flush_shift  = (fsm_state == S_FLUSH) && (flush_cnt <= FW'(IMG_W));
    assign shift        = accept || flush_shift;
    assign new_pix      = accept ? pix_in : 8'd0;
    assign emit         = (accept && (in_cnt >= PW'(IMG_W + 1))) || flush_shift;

    // FSM, input/flush counters and operands latched at start
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_state <= S_IDLE;
            in_cnt    <= '0;
            flush_cnt <= '0;
            mode      <= 3'd0;
            operand   <= 8'd0;
        end else begin
            case (fsm_state)
                S_IDLE: begin
                    if (start) begin
                        fsm_state <= S_STREAM;
                        mode      <= sel;
                        operand   <= val;
                        in_cnt    <= '0;
                        flush_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == PW'(NPIX - 1)) fsm_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FW'(IMG_W + 1)) fsm_state <= S_IDLE;
                end
                default: fsm_state <= S_IDLE;
            endcase
        end
    end

    // Line buffer write column and output raster position
    always_ff @(posedge clock) begin
        if (reset) begin
            col_ptr <= '0;
            out_c   <= '0;
            out_r   <= '0;
        end else if (fsm_state == S_IDLE && start) begin
            col_ptr <= '0;
            out_c   <= '0;
            out_r   <= '0;
        end else begin
            if (shift) col_ptr <= (col_ptr == CW'(IMG_W - 1)) ? '0 : col_ptr + 1'b1;
            if (emit) begin
                if (out_c == CW'(IMG_W - 1)) begin
                    out_c <= '0;
                    out_r <= out_r + 1'b1;
                end else begin
                    out_c <= out_c + 1'b1;
                end
            end
        end
    end

    // Window after this cycle's shift, used directly by the filter
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nw[i][0] = win[i][0];
            nw[i][1] = win[i][1];
        end
        nw[0][2] = lb_top[col_ptr];
        nw[1][2] = lb_mid[col_ptr];
        nw[2][2] = new_pix;
    end

    // Line buffers and window registers; contents need no reset
    always_ff @(posedge clock) begin
        if (shift) begin
            lb_mid[col_ptr] <= new_pix;
            lb_top[col_ptr] <= lb_mid[col_ptr];
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= nw[i][1];
                win[i][1] <= nw[i][2];
            end
        end
    end

    // Filter arithmetic on the shifted window
    always_comb begin
        lu = nw[0][0]; up = nw[0][1]; ru = nw[0][2];
        lf = nw[1][0]; p  = nw[1][1]; rt = nw[1][2];
        ld = nw[2][0]; dn = nw[2][1]; rd = nw[2][2];

        bright = {1'b0, p} + {1'b0, operand};
        gauss  = (z(p) << 2) + ((z(up) + z(dn) + z(lf) + z(rt)) << 1)
               + z(lu) + z(ru) + z(ld) + z(rd);
        sharp  = $signed(z(p) << 2) + $signed(z(p)) - $signed(z(up))
               - $signed(z(dn)) - $signed(z(lf)) - $signed(z(rt));
        gx     = $signed(z(ru)) + $signed(z(rt) << 1) + $signed(z(rd))
               - $signed(z(lu)) - $signed(z(lf) << 1) - $signed(z(ld));
        gy     = $signed(z(ld)) + $signed(z(dn) << 1) + $signed(z(rd))
               - $signed(z(lu)) - $signed(z(up) << 1) - $signed(z(ru));
        ax     = gx[11] ? -gx : gx;
        ay     = gy[11] ? -gy : gy;
        sob    = ax + ay;

        case (mode)
            3'd1:    result = 8'd255 - p;
            3'd2:    result = bright[8] ? 8'd255 : bright[7:0];
            3'd3:    result = 8'(gauss >> 4);
            3'd4:    result = (sharp < 0) ? 8'd0 :
                              (sharp > 12'sd255) ? 8'd255 : sharp[7:0];
            3'd5:    result = (sob > 12'd255) ? 8'd255 : sob[7:0];
            3'd6:    result = (p >= operand) ? 8'd255 : 8'd0;
            default: result = p;
        endcase

        border = (out_r == '0) || (out_r == RW'(IMG_H - 1)) ||
                 (out_c == '0) || (out_c == CW'(IMG_W - 1));
        if (border) result = p;
    end

    // Output register, strobe and end-of-frame pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_out       <= 8'd0;
            pix_out_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pix_out_valid <= emit;
            if (emit) pix_out <= result;
            frame_done    <= (fsm_state == S_FLUSH) && (flush_cnt == FW'(IMG_W + 1));
        end
    end

endmodule

// File: tb/tb_image_filter_3x3.sv
// Testbench for image_filter_3x3 on a reduced 32x16 frame. Expected pixels
// come from a direct arithmetic model of each filter on a stored image.
module tb_image_filter_3x3;

    localparam int W = 32;
    localparam int H = 16;
    localparam int N = W * H;

    // clock / reset block
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] val = 8'd0;
    logic [7:0] pix_in = 8'd0;
    logic pix_in_valid = 1'b0;
    logic pix_in_ready;
    logic [7:0] pix_out;
    logic pix_out_valid;
    logic busy;
    logic frame_done;
    logic [1:0] fsm_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    image_filter_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset(reset), .start(start), .sel(sel), .val(val),
        .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .busy(busy),
        .frame_done(frame_done), .fsm_state(fsm_state)
    );

    int total = 0;
    int bad = 0;

    int img [H][W];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] save_q[$];

    int first_valid_cyc, last_valid_cyc, done_cyc, done_cnt, hold_err;
    int acc_w1_cyc, busy_at_done;
    logic [7:0] last_out = 8'd0;
    bit rst_d = 1'b0;

    // output monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (reset || rst_d || pix_out_valid) last_out = pix_out;
        else if (pix_out !== last_out) hold_err++;
        rst_d = reset;
        if (pix_out_valid) begin
            if (got_q.size() == 0) first_valid_cyc = cyc;
            got_q.push_back(pix_out);
            last_valid_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    // reference model: one output pixel straight from the filter definitions
    function automatic int ref_pix(int r, int c, int s, int v);
        int p, up, dn, lf, rt, lu, ru, ld, rd, gx, gy, t;
        p = img[r][c];
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return p;
        up = img[r-1][c];   dn = img[r+1][c];
        lf = img[r][c-1];   rt = img[r][c+1];
        lu = img[r-1][c-1]; ru = img[r-1][c+1];
        ld = img[r+1][c-1]; rd = img[r+1][c+1];
        case (s)
            1: return 255 - p;
            2: return (p + v > 255) ? 255 : p + v;
            3: return (4*p + 2*(up + dn + lf + rt) + lu + ru + ld + rd) / 16;
            4: begin
                t = 5*p - up - dn - lf - rt;
                return (t < 0) ? 0 : (t > 255) ? 255 : t;
            end
            5: begin
                gx = (ru + 2*rt + rd) - (lu + 2*lf + ld);
                gy = (ld + 2*dn + rd) - (lu + 2*up + ru);
                t = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return (t > 255) ? 255 : t;
            end
            6: return (p >= v) ? 255 : 0;
            default: return p;
        endcase
    endfunction

    function automatic void build_exp(int s, int v);
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(8'(ref_pix(r, c, s, v)));
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver: start a frame, feed up to stop_at pixels, wait for frame_done
    task automatic run_frame(input int s, input int v, input int gap_pct,
                             input bit meddle, input int stop_at);
        int idx, guard;
        build_exp(s, v);
        got_q.delete();
        done_cnt = 0;
        hold_err = 0;
        first_valid_cyc = -1;
        acc_w1_cyc = -2;
        tick();
        start = 1'b1; sel = 3'(s); val = 8'(v);
        tick();
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < stop_at && guard < 20 * N) begin
            guard++;
            if (pix_in_ready && $urandom_range(99) >= gap_pct) begin
                pix_in = 8'(img[idx / W][idx % W]);
                pix_in_valid = 1'b1;
                if (idx == W + 1) acc_w1_cyc = cyc + 1;
                idx++;
            end else if (pix_in_ready) begin
                pix_in_valid = 1'b0;
                pix_in = 8'($urandom);
            end else begin
                pix_in_valid = 1'($urandom_range(1));
                pix_in = 8'($urandom);
            end
            if (meddle) begin
                start = ($urandom_range(3) == 0);
                sel = 3'($urandom);
                val = 8'($urandom);
            end
            tick();
        end
        pix_in_valid = 1'b0;
        start = 1'b0;
        total++;
        if (idx != stop_at) begin
            bad++;
            $display("FAIL feed_timeout fed=%0d want=%0d", idx, stop_at);
        end
        if (stop_at == N) begin
            guard = 0;
            while (done_cnt == 0 && guard < 4 * W + 20) begin
                guard++;
                tick();
            end
            repeat (3) tick();
            total++;
            if (done_cnt == 0) begin
                bad++;
                $display("FAIL done_timeout got=0 want=1");
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (pix_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", pix_in_ready); end
        total++; if (pix_out !== 8'd0) begin bad++; $display("FAIL rst_pix_out got=%0d want=0", pix_out); end
        total++; if (pix_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pix_out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", frame_done); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", fsm_state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass_ramp();
        int d;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r + c) & 255;
        run_frame(0, 0, 0, 1'b0, N);
        d = first_diff();
        total++; if (got_q.size() != N) begin bad++; $display("FAIL ramp_count got=%0d want=%0d", got_q.size(), N); end
        total++; if (d != -1) begin bad++; $display("FAIL ramp_pixel idx=%0d got=%0d want=%0d", d, got_q[d], exp_q[d]); end
        total++; if (first_valid_cyc != acc_w1_cyc) begin bad++; $display("FAIL first_valid_cycle got=%0d want=%0d", first_valid_cyc, acc_w1_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL done_pulses got=%0d want=1", done_cnt); end
        total++; if (done_cyc != last_valid_cyc + 1) begin bad++; $display("FAIL done_cycle got=%0d want=%0d", done_cyc, last_valid_cyc + 1); end
        total++; if (busy_at_done != 0) begin bad++; $display("FAIL busy_at_done got=%0d want=0", busy_at_done); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL pix_out_hold got=%0d want=0", hold_err); end
    endtask

    task automatic test_modes();
        int d, v;
        for (int s = 1; s < 8; s++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
            v = $urandom_range(255);
            run_frame(s, v, 0, 1'b0, N);
            d = first_diff();
            total++; if (got_q.size() != N) begin bad++; $display("FAIL mode%0d_count got=%0d want=%0d", s, got_q.size(), N); end
            total++; if (d != -1) begin bad++; $display("FAIL mode%0d_pixel idx=%0d got=%0d want=%0d", s, d, got_q[d], exp_q[d]); end
        end
    endtask

    task automatic fill_const(input int k);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = k;
    endtask

    task automatic test_bright_thresh();
        fill_const(100);
        run_frame(2, 200, 0, 1'b0, N);
        total++; if (got_q[W + 1] !== 8'd255) begin bad++; $display("FAIL bright_sat got=%0d want=255", got_q[W + 1]); end
        total++; if (got_q[0] !== 8'd100) begin bad++; $display("FAIL bright_border got=%0d want=100", got_q[0]); end
        fill_const(127);
        run_frame(6, 128, 0, 1'b0, N);
        total++; if (got_q[2 * W + 5] !== 8'd0) begin bad++; $display("FAIL thresh_below got=%0d want=0", got_q[2 * W + 5]); end
        fill_const(128);
        run_frame(6, 128, 0, 1'b0, N);
        total++; if (got_q[2 * W + 5] !== 8'd255) begin bad++; $display("FAIL thresh_equal got=%0d want=255", got_q[2 * W + 5]); end
    endtask

    task automatic test_sharpen();
        int d, nbad;
        fill_const(0);
        img[10][10] = 200;
        run_frame(4, 0, 0, 1'b0, N);
        d = first_diff();
        total++; if (got_q[10 * W + 10] !== 8'd255) begin bad++; $display("FAIL sharp_peak got=%0d want=255", got_q[10 * W + 10]); end
        total++; if (got_q[9 * W + 10] !== 8'd0) begin bad++; $display("FAIL sharp_up got=%0d want=0", got_q[9 * W + 10]); end
        total++; if (got_q[10 * W + 11] !== 8'd0) begin bad++; $display("FAIL sharp_right got=%0d want=0", got_q[10 * W + 11]); end
        total++; if (d != -1) begin bad++; $display("FAIL sharp_pixel idx=%0d got=%0d want=%0d", d, got_q[d], exp_q[d]); end
        fill_const(100);
        run_frame(4, 0, 0, 1'b0, N);
        nbad = 0;
        foreach (got_q[i]) if (got_q[i] !== 8'd100) nbad++;
        total++; if (nbad != 0 || got_q.size() != N) begin bad++; $display("FAIL sharp_const wrong=%0d count=%0d want 0 wrong of %0d", nbad, got_q.size(), N); end
    endtask

    task automatic test_sobel();
        int nbad, e, r, c;
        for (int rr = 0; rr < H; rr++) for (int cc = 0; cc < W; cc++) img[rr][cc] = (cc >= W / 2) ? 255 : 0;
        run_frame(5, 0, 0, 1'b0, N);
        nbad = 0;
        foreach (got_q[i]) begin
            r = i / W; c = i % W;
            if (r == 0 || r == H - 1 || c == 0 || c == W - 1) e = (c >= W / 2) ? 255 : 0;
            else e = (c == W / 2 - 1 || c == W / 2) ? 255 : 0;
            if (got_q[i] !== 8'(e)) nbad++;
        end
        total++; if (nbad != 0 || got_q.size() != N) begin bad++; $display("FAIL sobel_edge wrong=%0d count=%0d want 0 wrong of %0d", nbad, got_q.size(), N); end
    endtask

    task automatic test_gaps();
        int d, nbad;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
        run_frame(3, 0, 0, 1'b0, N);
        save_q = got_q;
        run_frame(3, 0, 50, 1'b1, N);
        d = first_diff();
        nbad = 0;
        foreach (got_q[i]) if (i < save_q.size() && got_q[i] !== save_q[i]) nbad++;
        total++; if (got_q.size() != save_q.size()) begin bad++; $display("FAIL gap_count got=%0d want=%0d", got_q.size(), save_q.size()); end
        total++; if (nbad != 0) begin bad++; $display("FAIL gap_vs_gapless wrong=%0d want=0", nbad); end
        total++; if (d != -1) begin bad++; $display("FAIL gap_pixel idx=%0d got=%0d want=%0d", d, got_q[d], exp_q[d]); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL gap_done got=%0d want=1", done_cnt); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL gap_hold got=%0d want=0", hold_err); end
    endtask

    task automatic test_reset_abort();
        int d, nval;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r + c) & 255;
        run_frame(0, 0, 0, 1'b0, 300);
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (pix_in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", pix_in_ready); end
        total++; if (pix_out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", pix_out_valid); end
        reset = 1'b0;
        nval = 0;
        repeat (2 * W) begin
            tick();
            if (pix_out_valid) nval++;
        end
        total++; if (nval != 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", nval); end
        run_frame(1, 0, 0, 1'b0, N);
        d = first_diff();
        total++; if (got_q.size() != N) begin bad++; $display("FAIL invert_count got=%0d want=%0d", got_q.size(), N); end
        total++; if (d != -1) begin bad++; $display("FAIL invert_pixel idx=%0d got=%0d want=%0d", d, got_q[d], exp_q[d]); end
        total++; if (got_q[W + 1] !== 8'd253) begin bad++; $display("FAIL invert_interior got=%0d want=253", got_q[W + 1]); end
        total++; if (got_q[W] !== 8'd1) begin bad++; $display("FAIL invert_border got=%0d want=1", got_q[W]); end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
            run_frame(4 + k, 0, 25, 1'b0, N);
            d = first_diff();
            total++; if (d != -1 || got_q.size() != N) begin bad++; $display("FAIL b2b%0d idx=%0d count=%0d want count %0d", k, d, got_q.size(), N); end
        end
    endtask

    initial begin
        test_reset();
        test_pass_ramp();
        test_modes();
        test_bright_thresh();
        test_sharpen();
        test_sobel();
        test_gaps();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
